// File: rtl/cajero_ctrl_pkg.sv
// rtl/cajero_ctrl_pkg.sv - shared state encoding and transaction-type constants for the ATM controller
package cajero_ctrl_pkg;

    // Controller states, 3-bit binary encoding
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PIN_ENTRY  = 3'd1,
        ST_PIN_CHECK  = 3'd2,
        ST_WAIT_MONTO = 3'd3,
        ST_DONE       = 3'd4,
        ST_BLOQUEO    = 3'd5
    } estado_t;

    // Meaning of tipo_trans
    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_ctrl_if.sv
// rtl/cajero_ctrl_if.sv - card, keypad, amount and status signals of the ATM controller
// Ports (slave = controller side):
//   in : tarjeta_recibida, pin, digito, digito_stb, tipo_trans, monto, monto_stb
//   out: balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
//        pin_incorrecto, advertencia, bloqueo
interface cajero_ctrl_if #(
    parameter int PIN_DIGITS = 4,
    parameter int BAL_W      = 32,
    parameter int AMT_W      = 32
);
    logic                    tarjeta_recibida;
    logic [4*PIN_DIGITS-1:0] pin;
    logic [3:0]              digito;
    logic                    digito_stb;
    logic                    tipo_trans;
    logic [AMT_W-1:0]        monto;
    logic                    monto_stb;
    logic [BAL_W-1:0]        balance;
    logic                    balance_actualizado;
    logic                    entregar_dinero;
    logic                    fondos_insuficientes;
    logic                    pin_incorrecto;
    logic                    advertencia;
    logic                    bloqueo;

    modport slave (
        input  tarjeta_recibida, pin, digito, digito_stb, tipo_trans, monto, monto_stb,
        output balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
               pin_incorrecto, advertencia, bloqueo
    );

    modport master (
        output tarjeta_recibida, pin, digito, digito_stb, tipo_trans, monto, monto_stb,
        input  balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
               pin_incorrecto, advertencia, bloqueo
    );
endinterface

// File: rtl/cajero_ctrl_pin_captura.sv
// rtl/cajero_ctrl_pin_captura.sv - keyed-PIN shift register and digit counter
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clr            clears the digit counter
//   digito         keyed BCD digit
//   digito_stb     digit valid (already gated to the entry state by the caller)
//   pin_ingresado  last PIN_DIGITS digits keyed, most recent in the low nibble
//   completo       this strobe captures the final digit of the PIN
module pin_captura #(
    parameter int PIN_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic [3:0]              digito,
    input  logic                    digito_stb,
    output logic [4*PIN_DIGITS-1:0] pin_ingresado,
    output logic                    completo
);
    localparam int PIN_W = 4 * PIN_DIGITS;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIN_DIGITS - 1);

    logic [PIN_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        completo = digito_stb && !clr && (cnt_q == LAST_IDX);
        if (clr) begin
            cnt_d = '0;
        end else if (digito_stb) begin
            // Truncating cast drops the oldest nibble off the top
            shift_d = PIN_W'({shift_q, digito});
            cnt_d   = completo ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pin_ingresado = shift_q;

endmodule

// File: rtl/cajero_ctrl.sv
// rtl/cajero_ctrl.sv - ATM transaction controller: PIN check, deposit/withdrawal, lockout
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      cajero_ctrl_if.slave: card/keypad/amount inputs, balance and status outputs
// All outputs come straight from flops.
module cajero_ctrl
    import cajero_ctrl_pkg::*;
#(
    parameter int PIN_DIGITS = 4,
    parameter int BAL_W      = 32,
    parameter int AMT_W      = 32,
    parameter int MAX_TRIES  = 3,
    parameter int INIT_BAL   = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    cajero_ctrl_if.slave bus
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_LOCK = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] TRIES_WARN = TRIES_W'(MAX_TRIES - 1);
    localparam logic [BAL_W-1:0]   BAL_RESET  = BAL_W'(INIT_BAL);

    estado_t             state_q, state_d;
    logic [TRIES_W-1:0]  tries_q, tries_d;
    logic [BAL_W-1:0]    balance_q, balance_d;
    logic                bal_upd_q, bal_upd_d;
    logic                entregar_q, entregar_d;
    logic                fondos_q, fondos_d;
    logic                pin_inc_q, pin_inc_d;
    logic                adv_q, adv_d;
    logic                bloqueo_q, bloqueo_d;

    logic [4*PIN_DIGITS-1:0] pin_ingresado;
    logic                    pin_completo;
    logic                    pin_clr;
    logic                    digito_en;
    logic                    pin_ok;
    logic [TRIES_W-1:0]      tries_inc;

    logic [BAL_W-1:0] monto_ext;
    logic [BAL_W-1:0] bal_suma;
    logic [BAL_W-1:0] bal_resta;
    logic             fondos_ok;

    // Digits only count while a card is in and we are collecting a PIN
    assign digito_en = bus.digito_stb && bus.tarjeta_recibida && (state_q == ST_PIN_ENTRY);
    assign pin_ok    = (pin_ingresado == bus.pin);
    assign tries_inc = tries_q + 1'b1;

    // Counter is held clear while idle and after a rejected PIN, so every
    // entry attempt starts from the first digit. Depends only on state, so
    // there is no loop through the capture block's completo output.
    assign pin_clr = (state_q == ST_IDLE) || ((state_q == ST_PIN_CHECK) && !pin_ok);

    pin_captura #(
        .PIN_DIGITS (PIN_DIGITS)
    ) u_pin_captura (
        .clk           (clk),
        .reset_n       (reset_n),
        .clr           (pin_clr),
        .digito        (bus.digito),
        .digito_stb    (digito_en),
        .pin_ingresado (pin_ingresado),
        .completo      (pin_completo)
    );

    // Balance datapath: one adder, one subtractor, one comparator
    assign monto_ext = BAL_W'(bus.monto);
    assign bal_suma  = balance_q + monto_ext;
    assign bal_resta = balance_q - monto_ext;
    assign fondos_ok = (monto_ext <= balance_q);

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        balance_d  = balance_q;
        bal_upd_d  = 1'b0;
        entregar_d = 1'b0;
        fondos_d   = 1'b0;
        pin_inc_d  = 1'b0;
        adv_d      = adv_q;
        bloqueo_d  = bloqueo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.tarjeta_recibida) state_d = ST_PIN_ENTRY;
            end

            ST_PIN_ENTRY: begin
                if (!bus.tarjeta_recibida) state_d = ST_IDLE;
                else if (pin_completo)     state_d = ST_PIN_CHECK;
            end

            ST_PIN_CHECK: begin
                // The verdict updates tries even if the card leaves this cycle
                if (pin_ok) begin
                    tries_d = '0;
                    adv_d   = 1'b0;
                    state_d = bus.tarjeta_recibida ? ST_WAIT_MONTO : ST_IDLE;
                end else begin
                    tries_d   = tries_inc;
                    pin_inc_d = 1'b1;
                    if (tries_inc == TRIES_WARN) adv_d = 1'b1;
                    if (tries_inc == TRIES_LOCK) begin
                        bloqueo_d = 1'b1;
                        state_d   = ST_BLOQUEO;
                    end else begin
                        state_d = bus.tarjeta_recibida ? ST_PIN_ENTRY : ST_IDLE;
                    end
                end
            end

            ST_WAIT_MONTO: begin
                if (!bus.tarjeta_recibida) begin
                    state_d = ST_IDLE;
                end else if (bus.monto_stb) begin
                    state_d = ST_DONE;
                    if (bus.tipo_trans == TIPO_DEPOSITO) begin
                        balance_d = bal_suma;
                        bal_upd_d = 1'b1;
                    end else if (fondos_ok) begin
                        balance_d  = bal_resta;
                        bal_upd_d  = 1'b1;
                        entregar_d = 1'b1;
                    end else begin
                        fondos_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (!bus.tarjeta_recibida) state_d = ST_IDLE;
            end

            ST_BLOQUEO: begin
                bloqueo_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tries_q    <= '0;
            balance_q  <= BAL_RESET;
            bal_upd_q  <= 1'b0;
            entregar_q <= 1'b0;
            fondos_q   <= 1'b0;
            pin_inc_q  <= 1'b0;
            adv_q      <= 1'b0;
            bloqueo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            balance_q  <= balance_d;
            bal_upd_q  <= bal_upd_d;
            entregar_q <= entregar_d;
            fondos_q   <= fondos_d;
            pin_inc_q  <= pin_inc_d;
            adv_q      <= adv_d;
            bloqueo_q  <= bloqueo_d;
        end
    end

    assign bus.balance              = balance_q;
    assign bus.balance_actualizado  = bal_upd_q;
    assign bus.entregar_dinero      = entregar_q;
    assign bus.fondos_insuficientes = fondos_q;
    assign bus.pin_incorrecto       = pin_inc_q;
    assign bus.advertencia          = adv_q;
    assign bus.bloqueo              = bloqueo_q;

endmodule
